// File: rtl/data_memory_pkg.sv
// Memory access modes shared between the data memory and the control decoder.
package MemoryModes;

  typedef enum logic [2:0] {
    NONE      = 3'd0,
    WORD      = 3'd1,
    HALFWORD  = 3'd2,
    BYTE      = 3'd3,
    WORDLEFT  = 3'd4,
    WORDRIGHT = 3'd5
  } memory_mode_e;

endpackage

// File: rtl/data_memory_byte_lane.sv
// One 8-bit byte lane: single synchronous write port, two asynchronous read ports.
module memory_byte_lane #(
  parameter int unsigned DEPTH_BITS = 14
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_BITS-1:0] waddr,
  input  logic [7:0]            wdata,
  input  logic [DEPTH_BITS-1:0] raddr_a,
  output logic [7:0]            rdata_a,
  input  logic [DEPTH_BITS-1:0] raddr_b,
  output logic [7:0]            rdata_b
);

  logic [7:0] mem_q [2**DEPTH_BITS];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_comb begin
    rdata_a = mem_q[raddr_a];
    rdata_b = mem_q[raddr_b];
  end

endmodule

// File: rtl/data_memory.sv
// Unified little-endian byte-addressable memory: combinational fetch port plus
// a data port with synchronous writes and combinational word/half/byte/lwl/lwr loads.
module data_memory
  import MemoryModes::*;
#(
  parameter int unsigned ADDR_BITS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [31:0] data,
  input  logic [2:0]  writeMode,
  input  logic [2:0]  readMode,
  input  logic        unsignedLoad,
  input  logic [31:0] pcAddress,
  output logic [31:0] dataOutput,
  output logic [31:0] pcDataOutput
);

  localparam int unsigned IDX_BITS = ADDR_BITS - 2;

  logic [IDX_BITS-1:0] data_idx;
  logic [IDX_BITS-1:0] pc_idx;
  logic [3:0]          wr_en;
  logic [31:0]         wr_data;
  logic [31:0]         rd_word;
  logic [15:0]         rd_half;
  logic [7:0]          rd_byte;
  int unsigned         kk;

  // Upper address bits wrap; fetch ignores the byte offset.
  logic unused_bits;
  assign unused_bits = ^{address[31:ADDR_BITS], pcAddress[31:ADDR_BITS], pcAddress[1:0]};

  always_comb begin
    data_idx = address[ADDR_BITS-1:2];
    pc_idx   = pcAddress[ADDR_BITS-1:2];
    kk       = 32'(address[1:0]);
  end

  // Lane enables and lane-aligned store data; rst low suppresses every write.
  always_comb begin
    wr_en   = '0;
    wr_data = '0;
    case (writeMode)
      WORD: begin
        wr_en   = '1;
        wr_data = data;
      end
      HALFWORD: begin
        if (address[1]) begin
          wr_en   = 4'b1100;
          wr_data = {data[15:0], 16'h0000};
        end else begin
          wr_en   = 4'b0011;
          wr_data = {16'h0000, data[15:0]};
        end
      end
      BYTE: begin
        wr_en[kk]          = 1'b1;
        wr_data[8*kk +: 8] = data[7:0];
      end
      WORDLEFT: begin
        for (int unsigned i = 0; i < 4; i++) begin
          if (i <= kk) begin
            wr_en[i]          = 1'b1;
            wr_data[8*i +: 8] = data[8*(3-kk+i) +: 8];
          end
        end
      end
      WORDRIGHT: begin
        for (int unsigned i = 0; i < 4; i++) begin
          if (i >= kk) begin
            wr_en[i]          = 1'b1;
            wr_data[8*i +: 8] = data[8*(i-kk) +: 8];
          end
        end
      end
      default: ;
    endcase
    wr_en = wr_en & {4{rst}};
  end

  for (genvar g = 0; g < 4; g++) begin : g_lane
    memory_byte_lane #(
      .DEPTH_BITS(IDX_BITS)
    ) u_lane (
      .clk     (clk),
      .we      (wr_en[g]),
      .waddr   (data_idx),
      .wdata   (wr_data[8*g +: 8]),
      .raddr_a (data_idx),
      .rdata_a (rd_word[8*g +: 8]),
      .raddr_b (pc_idx),
      .rdata_b (pcDataOutput[8*g +: 8])
    );
  end

  always_comb begin
    rd_half    = address[1] ? rd_word[31:16] : rd_word[15:0];
    rd_byte    = rd_word[8*kk +: 8];
    dataOutput = '0;
    case (readMode)
      WORD:     dataOutput = rd_word;
      HALFWORD: dataOutput = {{16{rd_half[15] & ~unsignedLoad}}, rd_half};
      BYTE:     dataOutput = {{24{rd_byte[7] & ~unsignedLoad}}, rd_byte};
      WORDLEFT: begin
        dataOutput = data;
        for (int unsigned i = 0; i < 4; i++) begin
          if (i <= kk) dataOutput[8*(3-kk+i) +: 8] = rd_word[8*i +: 8];
        end
      end
      WORDRIGHT: begin
        dataOutput = data;
        for (int unsigned i = 0; i < 4; i++) begin
          if (i >= kk) dataOutput[8*(i-kk) +: 8] = rd_word[8*i +: 8];
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_data_memory.sv
// Directed checks of the data_memory store/load modes, reset write blocking and fetch port.
module tb_data_memory;
  import MemoryModes::*;

  logic        clk;
  logic        rst;
  logic [31:0] address;
  logic [31:0] data;
  logic [2:0]  writeMode;
  logic [2:0]  readMode;
  logic        unsignedLoad;
  logic [31:0] pcAddress;
  logic [31:0] dataOutput;
  logic [31:0] pcDataOutput;

  int n_checks = 0;
  int n_fail   = 0;

  data_memory #(
    .ADDR_BITS(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .address      (address),
    .data         (data),
    .writeMode    (writeMode),
    .readMode     (readMode),
    .unsignedLoad (unsignedLoad),
    .pcAddress    (pcAddress),
    .dataOutput   (dataOutput),
    .pcDataOutput (pcDataOutput)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [2:0] m, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    readMode  = NONE;
    writeMode = m;
    address   = a;
    data      = d;
    @(posedge clk);
    #1;
    writeMode = NONE;
  endtask

  task automatic do_read(input string tag, input logic [2:0] rm, input logic uns,
                         input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp);
    readMode     = rm;
    unsignedLoad = uns;
    address      = a;
    data         = d;
    #1;
    check(tag, dataOutput, exp);
  endtask

  initial begin
    rst          = 1'b0;
    address      = '0;
    data         = '0;
    writeMode    = NONE;
    readMode     = NONE;
    unsignedLoad = 1'b0;
    pcAddress    = '0;
    #1;
    check("none_read_zero", dataOutput, 32'h0);
    #12;
    rst = 1'b1;

    // Word writes at the top of memory
    do_write(WORD, 32'd65532, 32'h22345678);
    do_write(WORD, 32'd65528, 32'h00000000);
    do_read("word_65532", WORD, 1'b0, 32'd65532, 32'h0, 32'h22345678);
    do_read("word_65528", WORD, 1'b0, 32'd65528, 32'h0, 32'h00000000);

    // Halfword stores and loads
    do_write(WORD, 32'd65528, 32'h33333333);
    do_write(HALFWORD, 32'd65528, 32'h00001FFF);
    do_read("half_merge", WORD, 1'b0, 32'd65528, 32'h0, 32'h33331FFF);
    do_write(HALFWORD, 32'd65528, 32'h0000FFFF);
    do_read("half_signed", HALFWORD, 1'b0, 32'd65528, 32'h0, 32'hFFFFFFFF);
    do_read("half_unsigned", HALFWORD, 1'b1, 32'd65528, 32'h0, 32'h0000FFFF);
    do_read("half_word_view", WORD, 1'b0, 32'd65528, 32'h0, 32'h3333FFFF);
    do_write(HALFWORD, 32'd65528, 32'h0000ABCD);
    do_write(HALFWORD, 32'd65530, 32'h00009845);
    do_write(WORD, 32'd65524, 32'h0);
    do_write(WORD, 32'd65532, 32'h0);
    do_read("half_pair", WORD, 1'b0, 32'd65528, 32'h0, 32'h9845ABCD);
    do_read("neigh_65524", WORD, 1'b0, 32'd65524, 32'h0, 32'h0);
    do_read("neigh_65532", WORD, 1'b0, 32'd65532, 32'h0, 32'h0);
    do_read("half_odd_addr", HALFWORD, 1'b0, 32'd65531, 32'h0, 32'hFFFF9845);

    // Byte stores and loads
    do_write(BYTE, 32'd65530, 32'h000000B2);
    do_write(BYTE, 32'd65528, 32'h000000D4);
    do_write(BYTE, 32'd65531, 32'h000000A1);
    do_write(BYTE, 32'd65529, 32'h000000C3);
    do_read("byte_word", WORD, 1'b0, 32'd65528, 32'h0, 32'hA1B2C3D4);
    do_read("ubyte_0", BYTE, 1'b1, 32'd65528, 32'h0, 32'h000000D4);
    do_read("ubyte_1", BYTE, 1'b1, 32'd65529, 32'h0, 32'h000000C3);
    do_read("ubyte_2", BYTE, 1'b1, 32'd65530, 32'h0, 32'h000000B2);
    do_read("ubyte_3", BYTE, 1'b1, 32'd65531, 32'h0, 32'h000000A1);
    do_read("sbyte_3", BYTE, 1'b0, 32'd65531, 32'h0, 32'hFFFFFFA1);
    do_read("sbyte_1", BYTE, 1'b0, 32'd65529, 32'h0, 32'hFFFFFFC3);

    // swl / lwl
    do_write(WORD, 32'd65528, 32'h0);
    do_write(WORDLEFT, 32'd65528, 32'h12345678);
    do_read("swl_k0_word", WORD, 1'b0, 32'd65528, 32'h0, 32'h00000012);
    do_read("lwl_k0", WORDLEFT, 1'b0, 32'd65528, 32'h0, 32'h12000000);
    do_write(WORDLEFT, 32'd65529, 32'h12345678);
    do_read("swl_k1_word", WORD, 1'b0, 32'd65528, 32'h0, 32'h00001234);
    do_read("lwl_k1", WORDLEFT, 1'b0, 32'd65529, 32'h0, 32'h12340000);
    do_read("lwl_k2_merge", WORDLEFT, 1'b0, 32'd65530, 32'h55667788, 32'h00123488);

    // swr / lwr
    do_write(WORD, 32'd65528, 32'h0);
    do_write(WORDRIGHT, 32'd65530, 32'hAABBCCDD);
    do_read("swr_k2_word", WORD, 1'b0, 32'd65528, 32'h0, 32'hCCDD0000);
    do_read("lwr_k2", WORDRIGHT, 1'b0, 32'd65530, 32'h11223344, 32'h1122CCDD);
    do_read("lwr_k0_full", WORDRIGHT, 1'b0, 32'd65528, 32'h11223344, 32'hCCDD0000);
    do_write(WORDRIGHT, 32'd65531, 32'h000000EE);
    do_read("swr_k3_word", WORD, 1'b0, 32'd65528, 32'h0, 32'hEEDD0000);

    // Writes blocked during reset, and by unused mode codes
    @(negedge clk);
    rst = 1'b0;
    do_write(WORD, 32'd65528, 32'hDEADBEEF);
    @(negedge clk);
    rst = 1'b1;
    do_read("reset_blocks_wr", WORD, 1'b0, 32'd65528, 32'h0, 32'hEEDD0000);
    do_write(3'd6, 32'd65528, 32'hFFFFFFFF);
    do_read("mode6_no_write", WORD, 1'b0, 32'd65528, 32'h0, 32'hEEDD0000);
    do_read("read_mode7_zero", 3'd7, 1'b0, 32'd65528, 32'h0, 32'h0);
    do_read("addr_wrap", WORD, 1'b0, 32'h0001FFF8, 32'h0, 32'hEEDD0000);

    // Fetch port
    pcAddress = 32'd65529;
    #1;
    check("pc_65529", pcDataOutput, 32'hEEDD0000);
    pcAddress = 32'd65528;
    #1;
    check("pc_65528", pcDataOutput, 32'hEEDD0000);
    pcAddress = 32'd65532;
    #1;
    check("pc_65532", pcDataOutput, 32'h00000000);

    // Same-cycle write and read: old value before the edge, new after
    @(negedge clk);
    readMode  = WORD;
    writeMode = WORD;
    address   = 32'd65532;
    data      = 32'h5A5AA5A5;
    #1;
    check("rw_before_edge", dataOutput, 32'h00000000);
    @(posedge clk);
    #1;
    check("rw_after_edge", dataOutput, 32'h5A5AA5A5);
    writeMode = NONE;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Unified byte-addressable 64 KiB memory for the MIPS-style CPU.
- Provides one combinational instruction-fetch port (pcAddress to pcDataOutput).
- Provides one data port with synchronous writes and combinational reads.
- Data port handles word, halfword, byte and unaligned-left/right (lwl/lwr, swl/swr) access.
- Little-endian: byte at address A is bits [7:0] of the word at A & ~3.

Parameters:
- ADDR_BITS, 16, byte-address width actually decoded (memory size 2^ADDR_BITS bytes); upper address bits ignored.

Ports:
- clk  in  1  system clock; writes on rising edge.
- rst  in  1  asynchronous active-low reset.
- address  in  32  data-port byte address.
- data  in  32  store data; for WORDLEFT/WORDRIGHT reads, the current register value to merge into.
- writeMode  in  3  MemoryModes store type; NONE = no write.
- readMode  in  3  MemoryModes load type; NONE = no read.
- unsignedLoad  in  1  1 = zero-extend HALFWORD/BYTE loads; 0 = sign-extend.
- pcAddress  in  32  instruction fetch byte address.
- dataOutput  out  32  data-port load result, combinational.
- pcDataOutput  out  32  instruction word, combinational.

Behaviour:
- Storage is four byte lanes of 2^(ADDR_BITS-2) entries. The word index is address[ADDR_BITS-1:2] and the byte offset k is address[1:0].
- Reset (rst=0, asynchronous) blocks all writes while asserted. Array contents are not cleared. Outputs are combinational and have no reset value.
- Writes commit on the rising clk edge when rst=1 and writeMode != NONE:
  - WORD: all 4 bytes = data; k ignored.
  - HALFWORD: lanes {2k', 2k'+1} with k' = address[1] get data[15:0]; address[0] ignored; other half untouched.
  - BYTE: lane k = data[7:0].
  - WORDLEFT (swl): lanes k..0 get data's top k+1 bytes, MSB-first downward. Lane k = data[31:24], lane k-1 = data[23:16], and so on.
  - WORDRIGHT (swr): lanes k..3 get data's low 4-k bytes. Lane k = data[7:0], lane k+1 = data[15:8], and so on.
  - Unused writeMode codes: no write.
- Reads are purely combinational from current contents, with zero latency:
  - WORD: full word.
  - HALFWORD: half selected by address[1], sign- or zero-extended per unsignedLoad.
  - BYTE: lane k, extended per unsignedLoad.
  - WORDLEFT (lwl): result[31:8(3-k)] = lanes k..0 (lane k in the MSB); remaining low bytes taken from data.
  - WORDRIGHT (lwr): result[8(4-k)-1:0] = lanes 3..k (lane k in the LSB); remaining high bytes taken from data.
  - NONE or unused codes: 0.
- unsignedLoad is ignored for WORD, WORDLEFT and WORDRIGHT.
- Same-cycle read and write to the same address: dataOutput shows the old data until the edge, then the new data.
- pcDataOutput = word at pcAddress[ADDR_BITS-1:2]; low two bits ignored; always active, independent of readMode.
- Addresses wrap modulo 2^ADDR_BITS.

Decomposition:
- Shared package MemoryModes holds the 3-bit enum NONE=0, WORD=1, HALFWORD=2, BYTE=3, WORDLEFT=4, WORDRIGHT=5. The ALU/control decoder imports the same package.
- One sub-module, memory_byte_lane: 8-bit-wide RAM with one write port and two asynchronous read ports, instantiated four times.
- The top level does lane-enable/shift generation and load extraction/extension.

Test Plan:
- WORD write 0x22345678 to 65532 and 0x0 to 65528; WORD reads return exactly those values, checked 1 time unit after address change with no clock edge in between.
- WORD 0x33333333 at 65528, then HALFWORD 0x1FFF: WORD read = 0x33331FFF. After HALFWORD 0xFFFF: signed HALFWORD read = 0xFFFFFFFF, unsigned = 0x0000FFFF. HALFWORD 0xABCD at 65528 and 0x9845 at 65530: word = 0x9845ABCD; neighbours at 65524/65532 remain 0.
- Bytes B2 to 65530, D4 to 65528, A1 to 65531, C3 to 65529: WORD read = 0xA1B2C3D4. Unsigned BYTE reads = D4, C3, B2, A1. Signed BYTE at 65531 = 0xFFFFFFA1.
- Clear the word, then WORDLEFT 0x12345678 at 65528: WORD read = 0x00000012; lwl (data=0) = 0x12000000. WORDLEFT at 65529: WORD = 0x00001234; lwl at 65529 = 0x12340000.
- WORDRIGHT 0xAABBCCDD at 65530 over a zeroed word: WORD = 0xCCDD0000. lwr at 65530 with data=0x11223344 = 0x1122CCDD.
- Hold rst=0 while issuing WORD write 0xDEADBEEF: contents unchanged. Drive pcAddress=65529 and 65528: both return the same word.
